// File: rtl/jt51_acc_fp_if.sv
// jt51_acc_fp_if
//   Bundles the slot-rate signals flowing from the operator pipeline into the
//   channel accumulator, and the stereo samples flowing back out.
//   master : operator pipeline side (drives phase flags, channel config, data)
//   slave  : accumulator side (jt51_acc_fp)
//   Signals:
//     cen                      clock enable
//     m1/m2/c1/c2_enters       one-hot phase flags, 8 slots each
//     op31_acc                 noise-capable slot marker
//     rl_I[1:0]                channel output enables (1 = right, 0 = left)
//     con_I[2:0]               channel connection algorithm
//     op_out[13:0]             operator output aligned to current slot
//     ne, noise_mix[11:0]      noise enable and noise sample
//     xleft/xright[15:0]       exact saturated stereo mix (registered)
//     left/right[15:0]         DAC-format quantised copies (combinational)
interface jt51_acc_fp_if;
  logic               cen;
  logic               m1_enters;
  logic               m2_enters;
  logic               c1_enters;
  logic               c2_enters;
  logic               op31_acc;
  logic        [1:0]  rl_I;
  logic        [2:0]  con_I;
  logic signed [13:0] op_out;
  logic               ne;
  logic signed [11:0] noise_mix;
  logic signed [15:0] xleft;
  logic signed [15:0] xright;
  logic signed [15:0] left;
  logic signed [15:0] right;

  modport master (
    output cen, m1_enters, m2_enters, c1_enters, c2_enters, op31_acc,
           rl_I, con_I, op_out, ne, noise_mix,
    input  xleft, xright, left, right
  );

  modport slave (
    input  cen, m1_enters, m2_enters, c1_enters, c2_enters, op31_acc,
           rl_I, con_I, op_out, ne, noise_mix,
    output xleft, xright, left, right
  );
endinterface

// File: rtl/jt51_acc_fp.sv
// jt51_acc_fp
//   Per-channel operator accumulator and stereo output stage of the JT51 FM
//   core. Operator outputs chosen by each channel's connection algorithm are
//   summed with 16-bit saturation in an 8-deep shift register (one word per
//   channel). Completed channel sums are mixed into 19-bit left/right
//   pre-accumulators during the C2 phase and latched, saturated, into
//   xleft/xright during the C1 phase. left/right are those samples truncated
//   to the YM2151 DAC floating-point format (10-bit mantissa, 3-bit exponent).
//   Ports:
//     clk  system clock
//     rst  asynchronous active-high reset
//     bus  jt51_acc_fp_if.slave (phase flags, channel config, data, outputs)
module jt51_acc_fp (
  input  logic         clk,
  input  logic         rst,
  jt51_acc_fp_if.slave bus
);

  // 17-bit channel sum clamped to 16 bits: overflow iff the top two bits differ
  function automatic logic signed [15:0] sat17(input logic signed [16:0] v);
    if (v[16] != v[15]) return v[16] ? 16'sh8000 : 16'sh7fff;
    return $signed(v[15:0]);
  endfunction

  // 19-bit stereo mix clamped to 16 bits
  function automatic logic signed [15:0] sat19(input logic signed [18:0] v);
    if (v > 19'sd32767)       return 16'sh7fff;
    else if (v < -19'sd32768) return 16'sh8000;
    return $signed(v[15:0]);
  endfunction

  // lin -> exp -> lin round trip. k counts redundant sign bits below bit 15
  // (capped at 6); the mantissa is the 10 bits starting at the sign, so the
  // exp-1 = 6-k bits below it are discarded. Those redundant upper bits are
  // exactly the sign extension of the mantissa, so an arithmetic shift right
  // then left by 6-k reproduces the sign-extended, re-scaled mantissa.
  function automatic logic signed [15:0] lin2fp(input logic signed [15:0] lin);
    logic [2:0] k;
    logic       run;
    logic [2:0] sh;
    k   = 3'd0;
    run = 1'b1;
    for (int i = 14; i >= 9; i--) begin
      if (run && (lin[i] == lin[15])) k = k + 3'd1;
      else                            run = 1'b0;
    end
    sh = 3'd6 - k;
    return (lin >>> sh) <<< sh;
  endfunction

  logic signed [13:0] op_val;
  logic               sum_en;
  logic signed [15:0] total;
  logic signed [16:0] sum17;
  logic signed [15:0] acc_d [8];
  logic signed [15:0] acc_q [8];
  logic signed [18:0] add_l, add_r;
  logic signed [18:0] pre_l_d, pre_l_q;
  logic signed [18:0] pre_r_d, pre_r_q;
  logic               sum_all_d, sum_all_q;
  logic signed [15:0] xleft_d, xleft_q;
  logic signed [15:0] xright_d, xright_q;

  always_comb begin
    // Noise replaces the operator only on the noise-capable slot
    op_val = (bus.ne && bus.op31_acc) ? $signed({{2{bus.noise_mix[11]}}, bus.noise_mix})
                                      : bus.op_out;

    // Which phases contribute to the channel sum for each algorithm
    case (bus.con_I)
      3'd0, 3'd1, 3'd2, 3'd3: sum_en = bus.m2_enters;
      3'd4:                   sum_en = bus.m1_enters | bus.m2_enters;
      3'd5, 3'd6:             sum_en = ~bus.c1_enters;
      default:                sum_en = 1'b1;
    endcase

    // Oldest word in the ring is this channel's value one phase ago
    total = acc_q[7];
    sum17 = $signed({{3{op_val[13]}}, op_val}) + $signed({total[15], total});

    // C2 starts a fresh channel sum; elsewhere add or pass through
    if (bus.c2_enters)
      acc_d[0] = sum_en ? $signed({{2{op_val[13]}}, op_val}) : 16'sd0;
    else if (sum_en)
      acc_d[0] = sat17(sum17);
    else
      acc_d[0] = total;
    for (int i = 1; i < 8; i++) acc_d[i] = acc_q[i-1];

    add_l = bus.rl_I[0] ? $signed({{3{total[15]}}, total}) : 19'sd0;
    add_r = bus.rl_I[1] ? $signed({{3{total[15]}}, total}) : 19'sd0;

    pre_l_d   = pre_l_q;
    pre_r_d   = pre_r_q;
    sum_all_d = sum_all_q;
    xleft_d   = xleft_q;
    xright_d  = xright_q;

    // During C2 the total is the channel's completed sum; the first C2 slot
    // after a latch reloads the mix instead of adding to it
    if (bus.c2_enters) begin
      pre_l_d   = sum_all_q ? pre_l_q + add_l : add_l;
      pre_r_d   = sum_all_q ? pre_r_q + add_r : add_r;
      sum_all_d = 1'b1;
    end

    if (bus.c1_enters) begin
      sum_all_d = 1'b0;
      xleft_d   = sat19(pre_l_q);
      xright_d  = sat19(pre_r_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) acc_q[i] <= 16'sd0;
      pre_l_q   <= 19'sd0;
      pre_r_q   <= 19'sd0;
      sum_all_q <= 1'b0;
      xleft_q   <= 16'sd0;
      xright_q  <= 16'sd0;
    end else if (bus.cen) begin
      for (int i = 0; i < 8; i++) acc_q[i] <= acc_d[i];
      pre_l_q   <= pre_l_d;
      pre_r_q   <= pre_r_d;
      sum_all_q <= sum_all_d;
      xleft_q   <= xleft_d;
      xright_q  <= xright_d;
    end
  end

  assign bus.xleft  = xleft_q;
  assign bus.xright = xright_q;
  assign bus.left   = lin2fp(xleft_q);
  assign bus.right  = lin2fp(xright_q);

endmodule

// File: tb/tb_jt51_acc_fp.sv
module tb_jt51_acc_fp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jt51_acc_fp_if bus();

  jt51_acc_fp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string              tag;
    logic signed [15:0] xl;
    logic signed [15:0] xr;
    logic signed [15:0] l;
    logic signed [15:0] r;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Per-channel configuration and per-slot operator data for the current test
  logic        [2:0]  con_cfg [8];
  logic        [1:0]  rl_cfg  [8];
  logic signed [13:0] op_cfg  [32];
  logic               ne_cfg;
  int                 noise_slot;
  logic signed [11:0] noise_val;

  task automatic chk16(input string tag, input logic signed [15:0] obs,
                       input logic signed [15:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  task automatic chk_outputs(input string tag, input exp_t e);
    chk16({tag, "_xleft"},  bus.xleft,  e.xl);
    chk16({tag, "_xright"}, bus.xright, e.xr);
    chk16({tag, "_left"},   bus.left,   e.l);
    chk16({tag, "_right"},  bus.right,  e.r);
  endtask

  task automatic idle_inputs();
    bus.cen       = 1'b0;
    bus.m1_enters = 1'b0;
    bus.m2_enters = 1'b0;
    bus.c1_enters = 1'b0;
    bus.c2_enters = 1'b0;
    bus.op31_acc  = 1'b0;
    bus.rl_I      = 2'b00;
    bus.con_I     = 3'd0;
    bus.op_out    = 14'sd0;
    bus.ne        = 1'b0;
    bus.noise_mix = 12'sd0;
  endtask

  task automatic cfg_clear();
    for (int i = 0; i < 8; i++) begin
      con_cfg[i] = 3'd0;
      rl_cfg[i]  = 2'b00;
    end
    for (int i = 0; i < 32; i++) op_cfg[i] = 14'sd0;
    ne_cfg     = 1'b0;
    noise_slot = -1;
    noise_val  = 12'sd0;
  endtask

  // Slot s: phase = s/8 (M1, M2, C1, C2), channel = s%8
  task automatic drive_slot(input int s);
    int ch;
    int ph;
    ch = s % 8;
    ph = s / 8;
    bus.cen       = 1'b1;
    bus.m1_enters = (ph == 0);
    bus.m2_enters = (ph == 1);
    bus.c1_enters = (ph == 2);
    bus.c2_enters = (ph == 3);
    bus.con_I     = con_cfg[ch];
    bus.rl_I      = rl_cfg[ch];
    bus.op_out    = op_cfg[s];
    bus.ne        = ne_cfg;
    bus.op31_acc  = (s == noise_slot);
    bus.noise_mix = noise_val;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // 20 disabled cycles with hostile inputs; nothing may move
  task automatic freeze(input exp_t e);
    for (int i = 0; i < 20; i++) begin
      bus.cen       = 1'b0;
      bus.m1_enters = 1'b1;
      bus.m2_enters = 1'b1;
      bus.c1_enters = 1'b1;
      bus.c2_enters = 1'b1;
      bus.con_I     = 3'd7;
      bus.rl_I      = 2'b11;
      bus.op_out    = 14'sd8191;
      bus.ne        = 1'b1;
      bus.op31_acc  = 1'b1;
      bus.noise_mix = 12'($urandom);
      @(posedge clk); #1;
    end
    chk_outputs("cen_hold", e);
  endtask

  task automatic run_frame(input bit do_chk, input int freeze_at,
                           input bit acc_chk, input logic signed [15:0] acc_req);
    exp_t e;
    bit   have;
    have = 1'b0;
    for (int s = 0; s < 32; s++) begin
      if (s == freeze_at && have) freeze(e);
      drive_slot(s);
      if (acc_chk && s == 24) chk16("ch0_total", dut.acc_q[7], acc_req);
      @(posedge clk); #1;
      if (do_chk && s == 16) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
          e    = sb.pop_front();
          have = 1'b1;
          chk_outputs(e.tag, e);
        end
      end
      if (s == 31 && have) chk_outputs({e.tag, "_hold"}, e);
    end
  endtask

  initial begin
    exp_t z;
    z = '{"reset", 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    cfg_clear();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset", z);
    chk16("reset_acc", dut.acc_q[7], 16'sd0);
    rst = 1'b0;

    // Left-only channel through the exact path
    cfg_clear();
    rl_cfg[0] = 2'b01;
    op_cfg[8] = 14'sd1001;
    run_frame(1'b0, -1, 1'b0, 16'sd0);
    run_frame(1'b0, -1, 1'b0, 16'sd0);
    sb.push_back('{"left_only", 16'sd1001, 16'sd0, 16'sd1000, 16'sd0});
    run_frame(1'b1, -1, 1'b1, 16'sd1001);

    // Clock enable low mid-frame, then the next latch must be unchanged
    sb.push_back('{"pre_freeze", 16'sd1001, 16'sd0, 16'sd1000, 16'sd0});
    run_frame(1'b1, 20, 1'b0, 16'sd0);
    sb.push_back('{"post_freeze", 16'sd1001, 16'sd0, 16'sd1000, 16'sd0});
    run_frame(1'b1, -1, 1'b1, 16'sd1001);

    // Positive saturation
    do_reset();
    cfg_clear();
    for (int i = 0; i < 8; i++) begin
      con_cfg[i] = 3'd7;
      rl_cfg[i]  = 2'b11;
    end
    for (int i = 0; i < 32; i++) op_cfg[i] = 14'sd8191;
    run_frame(1'b0, -1, 1'b0, 16'sd0);
    run_frame(1'b0, -1, 1'b0, 16'sd0);
    sb.push_back('{"pos_sat", 16'sh7fff, 16'sh7fff, 16'sh7fc0, 16'sh7fc0});
    run_frame(1'b1, -1, 1'b1, 16'sd32764);

    // Asynchronous reset mid-frame
    for (int s = 0; s < 10; s++) begin
      drive_slot(s);
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    chk_outputs("async_rst", z);
    chk16("async_rst_acc", dut.acc_q[7], 16'sd0);
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;

    // Negative saturation
    for (int i = 0; i < 32; i++) op_cfg[i] = -14'sd8192;
    run_frame(1'b0, -1, 1'b0, 16'sd0);
    run_frame(1'b0, -1, 1'b0, 16'sd0);
    sb.push_back('{"neg_sat", -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768});
    run_frame(1'b1, -1, 1'b1, -16'sd32768);

    // Noise substitution on ch7's M2 slot
    do_reset();
    cfg_clear();
    rl_cfg[7] = 2'b10;
    for (int i = 0; i < 32; i++) op_cfg[i] = 14'sd3000;
    ne_cfg     = 1'b1;
    noise_slot = 15;
    noise_val  = -12'sd5;
    run_frame(1'b0, -1, 1'b0, 16'sd0);
    run_frame(1'b0, -1, 1'b0, 16'sd0);
    sb.push_back('{"noise", 16'sd0, -16'sd5, 16'sd0, -16'sd5});
    run_frame(1'b1, -1, 1'b0, 16'sd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt51_acc_fp.md
# jt51_acc_fp

Per-channel operator accumulator and stereo output stage for the JT51 FM core. It sums the operator outputs selected by each channel's connection algorithm, with 16-bit saturation, and mixes all 8 channels into left/right sums. It then latches exact 16-bit outputs and emits copies of them quantised to a 10-bit mantissa and 3-bit exponent, reproducing the YM2151 DAC format. It sits between the operator pipeline and the audio output/DAC model.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `cen` in 1: clock enable; all state advances only on `clk` rising edges with `cen`=1.
- `m1_enters`, `m2_enters`, `c1_enters`, `c2_enters` in 1 each: phase flags. Exactly one is high, for 8 consecutive `cen` cycles (one slot per channel). Phases repeat as a 32-slot frame.
- `op31_acc` in 1: current slot is the noise-capable slot.
- `rl_I` in 2: output enables of the current channel; bit1 = right, bit0 = left.
- `con_I` in 3: connection algorithm of the current channel.
- `op_out` in 14 signed: operator output, already aligned to the current slot.
- `ne` in 1: noise enable.
- `noise_mix` in 12 signed: noise sample.
- `xleft`, `xright` out 16 signed, registered: exact saturated stereo mix.
- `left`, `right` out 16 signed, combinational: `xleft`/`xright` after floating-point quantisation.

## Operation
- Operand selection: `op_val` is `noise_mix` sign-extended to 14 bits when `ne` and `op31_acc` are both 1; otherwise it is `op_out`.
- Summing enable `sum_en`, selected by `con_I`:
  - con 0–3: `m2_enters`.
  - con 4: `m1_enters` or `m2_enters`.
  - con 5–6: not `c1_enters`.
  - con 7: always 1.
- Channel accumulator: 8-stage, 16-bit shift register. `total` is the word written 8 `cen` cycles earlier, i.e. the same channel one phase ago.
- Next word written to the accumulator:
  - During `c2_enters`: `sum_en` ? sign-extended `op_val` : 0. This starts a new channel sum.
  - Otherwise, with `sum_en`=1: the 17-bit sum `op_val`+`total`, saturated to 0x7FFF / 0x8000.
  - Otherwise (`sum_en`=0): `total` unchanged.
- Stereo mix: 19-bit pre-accumulators `pre_l` and `pre_r`, plus a flag `sum_all`.
  - On each `c2_enters` cycle, the channel's `total` (its completed previous sum) is added to `pre_l` if `rl_I[0]`=1 and to `pre_r` if `rl_I[1]`=1.
  - On the first `c2_enters` cycle after `sum_all`=0, the accumulator is loaded instead of added. That cycle sets `sum_all`=1.
- Output latch: each `c1_enters` cycle clears `sum_all` and loads `xleft`/`xright` with `pre_l`/`pre_r` saturated to 16 bits (>32767 gives 0x7FFF, < −32768 gives 0x8000).
- Quantisation (lin→exp→lin), applied per output:
  - k = number of consecutive bits from lin[14] downward equal to lin[15], capped at 6.
  - exp = 7−k; man = lin[15−k:6−k].
  - Output = man sign-extended and shifted left by exp−1.
  - Net effect: the value is truncated toward −∞ to 10 significant bits. Values in −512..511 pass exactly.

## Timing
- Reset: shift register, `pre_l`, `pre_r`, `sum_all`, `xleft` and `xright` all clear to 0. Consequently `left` = `right` = 0.
- Accumulator feedback latency is exactly 8 `cen` cycles. `cen`=0 freezes all state.
- `xleft`/`xright` update one `clk` edge after a `c1_enters` cycle. They hold their value through the other 24 slots of the frame.
- `left`/`right` follow `xleft`/`xright` combinationally, with zero cycle latency.
- The `c2_enters` accumulation and the `c1_enters` latch never coincide. If `rst` asserts mid-frame, the next complete C2 phase rebuilds the mix from scratch.

## Test plan
- Left-only channel, exact path: ch0 `con_I`=0, `rl_I`=01, `op_out`=1001 in ch0's M2-phase slot; all other channels have `rl_I`=00. Required after the next C2→C1 phases: `xleft`=1001, `left`=1000, `xright`=0.
- Positive saturation: all 8 channels `con_I`=7, `rl_I`=11, `op_out`=8191 in every slot. Required: each channel total = 32764; `xleft`=`xright`=0x7FFF; `left`=`right`=32704 (0x7FC0).
- Negative saturation: same setup with `op_out`=−8192. Required: channel total = −32768; `xleft`=`left`=−32768.
- Noise substitution: `ne`=1, `op31_acc`=1 on ch7's M2-phase slot, `noise_mix`=−5, `op_out`=3000, ch7 `con_I`=0, `rl_I`=10. Required: `xright`=−5, `right`=−5, `xleft`=0.
- Reset and clock enable:
  - Assert `rst` mid-frame: all outputs become 0 immediately.
  - Hold `cen`=0 for 20 cycles: outputs and accumulator contents unchanged.
